sunrise_sequencer: RTL
======================

# sunrise_sequencer

Frame-paced controller that drives the `fade_level` / `direction` pair consumed by the sun renderer. It sits beside the display timing generator in the pixel-clock domain and takes that generator's start-of-frame pulse. On start it ramps `fade_level` 0→255 with `direction=0` (sunrise, hang, sunset), then ramps 255→0 with `direction=1` (night). Outputs change only on frame boundaries, so a frame never shows a mixed sun position.

## Interface
- `STEPW`, default 4: width of the frames-per-step setting.
- `clk_pix`  in  1  pixel clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `frame`  in  1  single-cycle start-of-frame strobe from the display timing generator.
- `start`  in  1  single-cycle request to begin a cycle; honoured only in IDLE.
- `pause`  in  1  level; while high, `frame` strobes are ignored and all state holds.
- `loop_en`  in  1  level; sampled at cycle end: 1 = restart RAMP, 0 = return to IDLE.
- `step_frames`  in  STEPW  frames per fade step N; value 0 is treated as 1.
- `fade_level`  out  8  registered; feeds the renderer's `fade_level`.
- `direction`  out  1  registered; 0 = day, 1 = night.
- `state`  out  2  registered FSM code: IDLE=0, RAMP=1, NIGHT=2; 3 is unused.
- `busy`  out  1  registered; high when `state` is not IDLE.
- `cycle_done`  out  1  registered single-cycle pulse at the end of NIGHT.

## Operation
- Internal frame counter `cnt`, STEPW bits.
- Effective step count: Neff = max(`step_frames`, 1).
- A qualified frame is a cycle with `frame`=1, `pause`=0 and state RAMP or NIGHT.
- Step due: a qualified frame with `cnt` ≥ Neff−1.
  - On a step due, `cnt`←0.
  - On any other qualified frame, `cnt`←`cnt`+1.
  - Neff is compared live each frame, so lowering it mid-count fires on the next qualified frame.
- IDLE
  - `fade_level`=0, `direction`=0, `cnt`=0.
  - `start`=1 → RAMP. `fade_level` stays 0 and `cnt` is cleared.
- RAMP (`direction`=0)
  - On a step due with `fade_level`<255: `fade_level`+1.
  - On a step due with `fade_level`=255: go to NIGHT, `direction`←1, `fade_level` stays 255.
- NIGHT (`direction`=1)
  - On a step due with `fade_level`>0: `fade_level`−1.
  - On a step due with `fade_level`=0: `cycle_done`←1 for one cycle, `direction`←0, `cnt`←0. Then `loop_en`=1 → RAMP, otherwise → IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `frame` in IDLE.
  - `start` and `frame` arriving in the same IDLE cycle: the start is taken, the frame is not counted.
- Saturating arithmetic is never needed: the FSM transitions at 255 and 0, so `fade_level` never wraps.
- `pause` takes priority over `frame`. Pausing never clears `cnt`, and `start` is still accepted in IDLE while paused.
- Full cycle is 512·Neff qualified frames from start to `cycle_done`: 255 increments, 1 turn step, 255 decrements, 1 end step.

## Timing
- All outputs are registered. The response to a sampled `frame` or `start` is visible on the next `clk_pix` edge (latency 1).
- Reset values: `fade_level`=0, `direction`=0, `state`=IDLE, `busy`=0, `cycle_done`=0, `cnt`=0.
- Reset mid-operation aborts immediately. No `cycle_done` is emitted.
- `fade_level` and `direction` update only in the cycle after a `frame` strobe. They are therefore stable for the whole active frame that follows.
- `cycle_done` is high in exactly the same cycle that `state` first shows IDLE or RAMP after NIGHT.
- `busy` equals (`state` ≠ IDLE) at all times.

## Test plan
- Reset, then idle `frame` strobes with no start → all outputs stay 0, `state`=0.
- `step_frames`=1, `loop_en`=0, `start`, then 512 `frame` strobes:
  - `fade_level` reads 255 after strobe 255.
  - `direction`=1 after strobe 256.
  - `fade_level`=0 after strobe 511.
  - `cycle_done` pulses once after strobe 512, then `state`=IDLE.
- `step_frames`=3 → `fade_level` increments only on every 3rd strobe: 1 after strobe 3, 2 after strobe 6. `step_frames`=0 behaves exactly like 1.
- `pause` held high for 10 strobes mid-RAMP at `fade_level`=100 → value and `cnt` are frozen. After release, the count resumes from the frozen `cnt`.
- `loop_en`=1 at the end of NIGHT → `cycle_done` pulses, `state`=RAMP, `direction`=0, `fade_level`=0. A `start` during RAMP has no effect.
- Assert `rst` in NIGHT at `fade_level`=40 → the next cycle shows all reset values and no `cycle_done` pulse.

Source files
------------

// File: rtl/sunrise_sequencer.sv
// rtl/sunrise_sequencer.sv - frame-paced sunrise/sunset fade controller
//
// Ports:
//   clk_pix      in   pixel clock, sole clock
//   rst          in   synchronous active-high reset
//   frame        in   single-cycle start-of-frame strobe
//   start        in   single-cycle cycle request, honoured only in IDLE
//   pause        in   level, freezes all state and masks frame strobes
//   loop_en      in   level, sampled at cycle end: 1 = restart RAMP, 0 = IDLE
//   step_frames  in   frames per fade step (0 behaves as 1)
//   fade_level   out  registered fade value for the sun renderer
//   direction    out  registered, 0 = day ramp, 1 = night ramp
//   state        out  registered FSM code: IDLE=0, RAMP=1, NIGHT=2
//   busy         out  registered, high whenever state is not IDLE
//   cycle_done   out  registered single-cycle pulse at the end of NIGHT

module sunrise_sequencer #(
  parameter int STEPW = 4
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             frame,
  input  logic             start,
  input  logic             pause,
  input  logic             loop_en,
  input  logic [STEPW-1:0] step_frames,
  output logic [7:0]       fade_level,
  output logic             direction,
  output logic [1:0]       state,
  output logic             busy,
  output logic             cycle_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    NIGHT = 2'd2
  } state_t;

  state_t           st;
  logic [STEPW-1:0] cnt;
  logic [STEPW-1:0] neff_m1;
  logic             qual;
  logic             step_due;

  // Neff-1 with the zero setting folded onto one frame per step. Evaluated
  // live so a lowered setting takes effect on the very next qualified frame.
  assign neff_m1  = (step_frames == '0) ? '0 : step_frames - STEPW'(1);

  // Pause outranks the frame strobe; frames never count while idle.
  assign qual     = frame && !pause && (st != IDLE);

  // ">=" rather than "==" so a count left above a newly lowered setting
  // still fires instead of wrapping around.
  assign step_due = qual && (cnt >= neff_m1);

  assign state    = st;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      fade_level <= 8'd0;
      direction  <= 1'b0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;

      case (st)
        IDLE: begin
          fade_level <= 8'd0;
          direction  <= 1'b0;
          cnt        <= '0;
          // A frame in the same cycle as start is deliberately not counted.
          if (start) begin
            st   <= RAMP;
            busy <= 1'b1;
          end
        end

        RAMP: begin
          if (step_due) begin
            cnt <= '0;
            if (fade_level != 8'd255) begin
              fade_level <= fade_level + 8'd1;
            end else begin
              // Turn step: level holds at full brightness, only direction flips.
              st        <= NIGHT;
              direction <= 1'b1;
            end
          end else if (qual) begin
            cnt <= cnt + STEPW'(1);
          end
        end

        NIGHT: begin
          if (step_due) begin
            cnt <= '0;
            if (fade_level != 8'd0) begin
              fade_level <= fade_level - 8'd1;
            end else begin
              // End step: the done pulse lands in the same cycle the new
              // state becomes visible.
              cycle_done <= 1'b1;
              direction  <= 1'b0;
              if (loop_en) begin
                st <= RAMP;
              end else begin
                st   <= IDLE;
                busy <= 1'b0;
              end
            end
          end else if (qual) begin
            cnt <= cnt + STEPW'(1);
          end
        end

        default: begin
          st         <= IDLE;
          cnt        <= '0;
          fade_level <= 8'd0;
          direction  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
